piso_serializer: RTL

//   Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 37 +++
 rtl/piso_serializer.sv | 95 +++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link: line states and the default word width.
// The matching SIPO receiver imports the same package.
package piso_serializer_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial word: clears on a new word, steps once per bit,
// and flags the final bit position. It saturates at WIDTH-1 and never wraps.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          at_last_o
);

  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_last_o = (cnt_q == LAST_POS);
  assign cnt_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !at_last_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready load
// and shifts it out one bit per clock on q/qbar with frame and last markers.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             qbar,
  output logic             frame,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             q_q, q_d;
  logic             cnt_clr, cnt_inc, at_last;
  logic [CW-1:0]    cnt;
  logic             accept;

  function automatic logic emit_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .cnt_o    (cnt),
    .at_last_o(at_last)
  );

  // Ready in the last-bit cycle lets the next word follow with no idle gap.
  assign load_ready = (state_q == ST_IDLE) | at_last;
  assign accept     = load_valid & load_ready;

  assign q     = q_q;
  assign qbar  = ~q_q;
  assign frame = (state_q == ST_SHIFT);
  assign last  = frame & at_last;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    q_d     = q_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (accept) begin
      shreg_d = din;
      q_d     = emit_bit(din);
      state_d = ST_SHIFT;
      cnt_clr = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (!at_last) begin
        shreg_d = shift_word(shreg_q);
        q_d     = emit_bit(shift_word(shreg_q));
        cnt_inc = 1'b1;
      end else begin
        state_d = ST_IDLE;
        q_d     = 1'b0;
        cnt_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      q_q     <= q_d;
    end
  end

  // The counter only holds at WIDTH-1 when it is the final bit of a live word.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
